// File: rtl/cell3_vecchk.sv
// rtl/cell3_vecchk.sv - exhaustive 8-vector checker for a 3-input cell
module cell3_vecchk #(
    parameter int         SETTLE = 2,
    parameter logic [7:0] EXP    = 8'b0000_0001
) (
    input  logic       ck,
    input  logic       nrst,
    input  logic       start,
    input  logic       abort,
    input  logic       nq,
    output logic       i0,
    output logic       i1,
    output logic       i2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic       fail_valid,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t     state, state_nx;
    logic [2:0] vec, vec_nx;
    logic [3:0] cnt, cnt_nx;
    logic [2:0] stim, stim_nx;
    logic       done_nx, pass_nx, fv_nx;
    logic [3:0] err_nx;
    logic [2:0] ff_nx;
    logic       mismatch;

    assign mismatch = (nq != EXP[vec]);
    assign busy     = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign {i2, i1, i0} = stim;

    // State and datapath registers; reset clears everything asynchronously
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            vec        <= 3'd0;
            cnt        <= 4'd0;
            stim       <= 3'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= 4'd0;
            fail_valid <= 1'b0;
            first_fail <= 3'd0;
        end else begin
            state      <= state_nx;
            vec        <= vec_nx;
            cnt        <= cnt_nx;
            stim       <= stim_nx;
            done       <= done_nx;
            pass       <= pass_nx;
            err_cnt    <= err_nx;
            fail_valid <= fv_nx;
            first_fail <= ff_nx;
        end
    end

    // Next-state and next-value logic; abort beats start while busy
    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        cnt_nx   = cnt;
        done_nx  = done;
        pass_nx  = pass;
        err_nx   = err_cnt;
        fv_nx    = fail_valid;
        ff_nx    = first_fail;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx = ST_SETTLE;
                    vec_nx   = 3'd0;
                    cnt_nx   = SETTLE_LD;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                    err_nx   = 4'd0;
                    fv_nx    = 1'b0;
                    ff_nx    = 3'd0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_nx = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_nx = (err_cnt == 4'd15) ? err_cnt : err_cnt + 4'd1;
                        if (!fail_valid) begin
                            fv_nx = 1'b1;
                            ff_nx = vec;
                        end
                    end
                    if (vec == 3'd7) begin
                        state_nx = ST_DONE;
                        done_nx  = 1'b1;
                        pass_nx  = (err_nx == 4'd0);
                    end else begin
                        state_nx = ST_SETTLE;
                        vec_nx   = vec + 3'd1;
                        cnt_nx   = SETTLE_LD;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        stim_nx = ((state_nx == ST_SETTLE) || (state_nx == ST_SAMPLE)) ? vec_nx : 3'd0;
    end

endmodule

// File: tb/tb_cell3_vecchk.sv
// tb/tb_cell3_vecchk.sv - self-checking bench for cell3_vecchk
module tb_cell3_vecchk;

    logic ck = 1'b0;
    logic nrst = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
    int   nq_mode = 0;
    logic nq_a, nq_b;
    logic i0_a, i1_a, i2_a, busy_a, done_a, pass_a, fv_a;
    logic i0_b, i1_b, i2_b, busy_b, done_b, pass_b, fv_b;
    logic [3:0] err_a, err_b;
    logic [2:0] ff_a, ff_b;
    logic [2:0] stim_a, stim_b;

    int checks = 0;
    int errors = 0;

    always #5 ck = ~ck;

    assign stim_a = {i2_a, i1_a, i0_a};
    assign stim_b = {i2_b, i1_b, i0_b};
    assign nq_a = (nq_mode == 0) ? ~(|stim_a) : (nq_mode == 1) ? 1'b0 : 1'b1;
    assign nq_b = |stim_b;

    cell3_vecchk dut_a (
        .ck(ck), .nrst(nrst), .start(start_a), .abort(abort), .nq(nq_a),
        .i0(i0_a), .i1(i1_a), .i2(i2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .fail_valid(fv_a), .first_fail(ff_a)
    );

    cell3_vecchk #(.SETTLE(1), .EXP(8'b1111_1110)) dut_b (
        .ck(ck), .nrst(nrst), .start(start_b), .abort(abort), .nq(nq_b),
        .i0(i0_b), .i1(i1_b), .i2(i2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .fail_valid(fv_b), .first_fail(ff_b)
    );

    // Model: a sweep is 8 vectors of P cycles each; edge index k since start
    // selects vector k/P, and the last cycle of each vector is the sample.
    logic [7:0] expv [2] = '{8'h01, 8'hFE};
    int         per  [2] = '{3, 2};
    bit         m_run [2], m_done [2], m_pass [2], m_fv [2];
    int         m_k [2], m_err [2], m_ff [2];

    always @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fv[i] = 0;
                m_k[i] = 0; m_err[i] = 0; m_ff[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic bit st = (i == 0) ? start_a : start_b;
                automatic bit q  = (i == 0) ? nq_a : nq_b;
                automatic int v;
                if (m_run[i]) begin
                    if (abort) begin
                        m_run[i] = 0;
                    end else begin
                        if (m_k[i] % per[i] == per[i] - 1) begin
                            v = m_k[i] / per[i];
                            if (q != expv[i][v]) begin
                                if (m_err[i] < 15) m_err[i]++;
                                if (!m_fv[i]) begin m_fv[i] = 1; m_ff[i] = v; end
                            end
                        end
                        m_k[i]++;
                        if (m_k[i] == 8 * per[i]) begin
                            m_run[i] = 0; m_done[i] = 1; m_pass[i] = (m_err[i] == 0);
                        end
                    end
                end else if (st) begin
                    m_run[i] = 1; m_k[i] = 0; m_done[i] = 0; m_pass[i] = 0;
                    m_err[i] = 0; m_fv[i] = 0; m_ff[i] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [13:0] model_vec(input int i);
        logic [2:0] s;
        s = m_run[i] ? 3'(m_k[i] / per[i]) : 3'd0;
        return {m_run[i], m_done[i], m_pass[i] && m_done[i], 4'(m_err[i]),
                m_fv[i], 3'(m_ff[i]), s};
    endfunction

    task automatic compare();
        check("cycle_a", int'({busy_a, done_a, pass_a, err_a, fv_a, ff_a, stim_a}), int'(model_vec(0)));
        check("cycle_b", int'({busy_b, done_b, pass_b, err_b, fv_b, ff_b, stim_b}), int'(model_vec(1)));
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_outs"}, int'({busy_a, done_a, pass_a, err_a, fv_a, ff_a, stim_a}), 0);
    endtask

    // Runs one sweep; cyc counts edges from the start edge to the done edge
    task automatic run(input int which, input bit mid, output int cyc);
        @(negedge ck);
        if (which == 0) start_a = 1; else start_b = 1;
        @(posedge ck); #1;
        start_a = 0; start_b = 0; cyc = 0;
        while (((which == 0) ? !done_a : !done_b) && cyc < 200) begin
            @(posedge ck); #1;
            cyc++;
            if (which == 0) start_a = mid && (cyc == 10);
        end
        start_a = 0;
    endtask

    initial begin
        int cyc;
        fork
            forever begin @(negedge ck); compare(); end
        join_none
        #1 check_reset_a("reset_hold");
        repeat (3) @(negedge ck);
        nrst = 1;
        @(negedge ck);
        check_reset_a("reset_release");

        nq_mode = 0;
        run(0, 0, cyc);
        check("nor_len", cyc, 24);
        check("nor_pass", int'({pass_a, err_a, fv_a}), 9'h100 >> 3);

        nq_mode = 1;
        run(0, 0, cyc);
        check("st0_len", cyc, 24);
        check("st0_res", int'({pass_a, err_a, fv_a, ff_a}), int'({1'b0, 4'd1, 1'b1, 3'd0}));

        nq_mode = 2;
        run(0, 0, cyc);
        check("st1_res", int'({pass_a, err_a, fv_a, ff_a}), int'({1'b0, 4'd7, 1'b1, 3'd1}));

        @(negedge ck); start_a = 1;
        @(negedge ck); start_a = 0;
        cyc = 0;
        while (stim_a != 3'd4 && cyc < 100) begin @(posedge ck); #1; cyc++; end
        check("abort_reach", int'(stim_a), 4);
        abort = 1;
        @(posedge ck); #1;
        abort = 0;
        check("abort_res", int'({busy_a, done_a, pass_a, stim_a, err_a, fv_a, ff_a}),
              int'({3'b000, 3'd0, 4'd3, 1'b1, 3'd1}));
        nq_mode = 0;
        run(0, 0, cyc);
        check("post_abort_len", cyc, 24);
        check("post_abort_res", int'({pass_a, err_a, fv_a}), int'({1'b1, 4'd0, 1'b0}));

        @(negedge ck); start_a = 1;
        @(negedge ck); start_a = 0;
        @(posedge ck); #2;
        check("pre_rst_busy", int'(busy_a), 1);
        nrst = 0;
        #1 check_reset_a("async_rst");
        @(negedge ck); nrst = 1;
        run(0, 1, cyc);
        check("start_ignored_len", cyc, 24);
        check("start_ignored_res", int'({pass_a, err_a}), int'({1'b1, 4'd0}));

        run(1, 0, cyc);
        check("or3_len", cyc, 16);
        check("or3_res", int'({pass_b, err_b, fv_b}), int'({1'b1, 4'd0, 1'b0}));

        repeat (2) @(negedge ck);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cell3_vecchk.md
CELL3_VECCHK -- requirements
Module: cell3_vecchk

Interface
REQ-001 SETTLE, 2, number of cycles each input vector is held before the response is sampled; legal range 1..15.
REQ-002 EXP, 8'b0000_0001, expected-response truth table; bit k is the expected nq for vector k = {i2,i1,i0}; the default is the 3-input NOR function.
REQ-003 ck  input  1  single clock; all state changes on its rising edge.
REQ-004 nrst  input  1  reset; asynchronous and active-low.
REQ-005 start  input  1  single-cycle request to run one full 8-vector sweep.
REQ-006 abort  input  1  synchronous request to end a sweep immediately.
REQ-007 nq  input  1  response from the 3-input cell under test; treated as synchronous to ck.
REQ-008 i0, i1, i2  output  1 each  stimulus to the cell under test; registered.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high after a sweep completes; held until the next start or reset.
REQ-011 pass  output  1  qualified by done; high when err_cnt == 0.
REQ-012 err_cnt  output  4  number of mismatching vectors in the last sweep; saturates at 15.
REQ-013 fail_valid  output  1  high once at least one mismatch has been recorded in the current or last sweep.
REQ-014 first_fail  output  3  vector index of the first mismatch; meaningful only when fail_valid = 1.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETTLE, SAMPLE and DONE.
REQ-016 The block SHALL hold a 3-bit vector counter vec; {i2,i1,i0} SHALL equal vec in SETTLE and SAMPLE, and 3'b000 in IDLE and DONE.
REQ-017 start in IDLE or DONE SHALL, on the same edge:
  - clear vec, err_cnt, fail_valid and first_fail;
  - clear done;
  - load the settle counter with SETTLE;
  - enter SETTLE.
REQ-018 start SHALL be ignored in SETTLE and SAMPLE.
REQ-019 SETTLE SHALL last exactly SETTLE cycles; the settle counter SHALL decrement each cycle, and the FSM SHALL enter SAMPLE on the edge at which the counter reaches 1.
REQ-020 SAMPLE SHALL last one cycle; in that cycle nq is compared with EXP[vec], and a mismatch SHALL:
  - increment err_cnt, saturating at 15;
  - if fail_valid = 0, load first_fail with vec and set fail_valid.
REQ-021 On leaving SAMPLE, the FSM SHALL:
  - if vec = 7, enter DONE with done = 1;
  - otherwise increment vec, reload the settle counter, and re-enter SETTLE.
REQ-022 A sweep SHALL last 8*(SETTLE+1) cycles, from the start edge to the edge that sets done.
REQ-023 busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-024 pass SHALL be a registered copy of (err_cnt == 0), updated when DONE is entered, and 0 whenever done = 0.
REQ-025 abort in SETTLE or SAMPLE SHALL:
  - enter IDLE on the next edge;
  - drive the stimulus to 0;
  - leave done = 0 and pass = 0;
  - retain err_cnt, fail_valid and first_fail;
  - discard any comparison in that cycle.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 If abort and start are both high, abort SHALL win when busy; start SHALL win when not busy.

Reset
REQ-028 Asserting nrst low SHALL immediately, without waiting for a clock edge:
  - force the FSM to IDLE;
  - set vec = 0 and i0 = i1 = i2 = 0;
  - set busy = 0, done = 0, pass = 0;
  - set err_cnt = 0, fail_valid = 0, first_fail = 0.
REQ-029 Reset asserted mid-sweep SHALL discard the sweep.
REQ-030 The first start accepted after nrst rises SHALL begin a full sweep from vec = 0.

Verification
REQ-031 A bench SHALL cover the following scenarios with default parameters:
  - Ideal NOR3 model on nq, one start pulse -> done at cycle 24; pass = 1, err_cnt = 0, fail_valid = 0; stimulus steps 000..111, each held 3 cycles.
  - nq stuck at 0 -> done at cycle 24; pass = 0, err_cnt = 1, first_fail = 0.
  - nq stuck at 1 -> err_cnt = 7, first_fail = 1, pass = 0.
  - abort asserted during vec = 4 -> IDLE next edge; stimulus 000, busy = 0, done = 0; err_cnt retained; a following start yields a full clean sweep.
  - nrst pulsed low mid-SETTLE with no clock edge -> all outputs at their reset values immediately; start pulsed while busy -> ignored, sweep length unchanged.
  - SETTLE = 1, EXP = 8'b1111_1110 with an ideal OR3 model on nq -> done after 16 cycles, pass = 1.
